// File: rtl/cw305_bridge_pkg.sv
// Shared types and constants for the burst address counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cw305_bridge_pkg;

    // Burst sequencer states. The binary values are relied on by the
    // legacy-style localparam state constants in burst_addr_counter.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte increment per beat for the default 32-bit data path.
    localparam int unsigned DEFAULT_STEP = 4;

endpackage

// File: rtl/burst_addr_counter_if.sv
// Bundle of control inputs and beat outputs for burst_addr_counter.
// Latency: n/a (wiring only).
// Backpressure: advance is the consumer grant; addr holds while it is low.
//   master: drives load/start/abort/base_addr/burst_len/wrap_mask/advance,
//           observes addr/valid/busy/done/beats_left.
//   slave : the counter itself (opposite directions).
interface burst_addr_counter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) ();
    logic              load;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  burst_len;
    logic [ADDR_W-1:0] wrap_mask;
    logic              advance;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  beats_left;

    modport master (
        output load, start, abort, base_addr, burst_len, wrap_mask, advance,
        input  addr, valid, busy, done, beats_left
    );

    modport slave (
        input  load, start, abort, base_addr, burst_len, wrap_mask, advance,
        output addr, valid, busy, done, beats_left
    );
endinterface

// File: rtl/step_counter.sv
// Address register: parallel load or advance by STEP, else hold.
// Latency: new value visible one cycle after load_en/step_en.
// Backpressure: none; holds whenever neither enable is set.
// Ports: clk, rst_n (async active-low), load_en/load_val, step_en,
//        wrap_mask (only used when BURST_WRAP_EN is defined), q.
module step_counter #(
    parameter int          W    = 32,
    parameter int unsigned STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         step_en,
    input  logic [W-1:0] wrap_mask,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] inc;
    logic [W-1:0] next_addr;

    // Plain add; overflow wraps modulo 2^W.
    assign inc = q_q + W'(STEP);

`ifdef BURST_WRAP_EN
    // Bits outside the mask are frozen so the address cycles inside an
    // aligned window.
    assign next_addr = (q_q & ~wrap_mask) | (inc & wrap_mask);
`else
    logic unused_wrap;
    assign unused_wrap = ^wrap_mask;
    assign next_addr   = inc;
`endif

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = load_val;
        end else if (step_en) begin
            q_d = next_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/burst_addr_counter.sv
// Burst address generator: issues burst_len beat addresses from base_addr.
// Latency: valid one cycle after start; N beats with advance high -> done at cycle N+1.
// Backpressure: addr/beats_left hold while advance is low; abort drops the burst.
// Ports: clk, rst_n (async active-low), bus (burst_addr_counter_if.slave).
// Optional: define BURST_WRAP_EN to wrap addresses inside the wrap_mask window.
module burst_addr_counter
    import cw305_bridge_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          LEN_W  = 16,
    parameter int unsigned STEP   = DEFAULT_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    burst_addr_counter_if.slave bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] beats_left_q, beats_left_d;
    logic             addr_load;
    logic             addr_step;

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        addr_load    = 1'b0;
        addr_step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // A zero-length burst skips RUN so valid never rises.
                    if (bus.burst_len != '0) begin
                        state_d      = S_RUN;
                        beats_left_d = bus.burst_len;
                        addr_load    = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (bus.load) begin
                    addr_load = 1'b1;
                end
            end
            S_RUN: begin
                // abort outranks advance: the current beat is not taken.
                if (bus.abort) begin
                    state_d      = S_IDLE;
                    beats_left_d = '0;
                end else if (bus.advance) begin
                    addr_step    = 1'b1;
                    beats_left_d = beats_left_q - LEN_W'(1);
                    if (beats_left_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (bus.abort) begin
                    beats_left_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
        end
    end

    step_counter #(
        .W    (ADDR_W),
        .STEP (STEP)
    ) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (addr_load),
        .load_val  (bus.base_addr),
        .step_en   (addr_step),
        .wrap_mask (bus.wrap_mask),
        .q         (bus.addr)
    );

    assign bus.valid      = (state_q == S_RUN);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.beats_left = beats_left_q;
endmodule

// File: tb/tb_burst_addr_counter.sv
// Self-checking bench for burst_addr_counter against an address-list model.
// Latency: n/a.
// Backpressure: advance driven always-high, toggling or random.
module tb_burst_addr_counter;
    localparam int          ADDR_W = 32;
    localparam int          LEN_W  = 16;
    localparam int unsigned STEP   = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] model_addr;
    bit   wrap_en;

    burst_addr_counter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    burst_addr_counter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Address of beat i: linear offset from base; with wrapping only the
    // bits inside the mask move.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i,
                                              input logic [31:0] mask);
        logic [31:0] off;
        off = base + 32'(i * int'(STEP));
        if (wrap_en) return (base & ~mask) | (off & mask);
        return off;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        bus.load = 0; bus.start = 0; bus.abort = 0; bus.advance = 0;
        bus.base_addr = 0; bus.burst_len = 0; bus.wrap_mask = 0;
        #3;
        checks++;
        if ({bus.valid, bus.busy, bus.done} !== 3'b000 || bus.addr !== 32'h0 || bus.beats_left !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v/b/d=%b%b%b addr=%h beats=%0d, expected 000 addr=0 beats=0",
                     bus.valid, bus.busy, bus.done, bus.addr, bus.beats_left);
        end
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b addr=%h, expected busy=0 addr=0", bus.busy, bus.addr);
        end
        model_addr = 32'h0;
    endtask

    // mode 0: advance always high, 1: toggling 1,0,..., 2: random plus
    // random start/load/base noise while running (must be ignored).
    task automatic run_burst(input logic [31:0] base, input int len, input int mode,
                             input logic [31:0] mask, input string name);
        int idx, cyc;
        bit seen_done, adv;
        bus.wrap_mask = mask;
        bus.base_addr = base;
        bus.burst_len = 16'(len);
        bus.start = 1; bus.advance = 0;
        tick;
        bus.start = 0;
        idx = 0; cyc = 1; seen_done = 0;
        for (int b = 0; b < 200; b++) begin
            if (bus.done === 1'b1) begin
                seen_done = 1;
                checks++;
                if (idx != len || bus.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_done_beats: got beats=%0d valid=%b, expected beats=%0d valid=0",
                             name, idx, bus.valid, len);
                end
                if (mode == 0) begin
                    checks++;
                    if (cyc != len + 1) begin
                        errors++;
                        $display("FAIL %s_done_latency: got cycle %0d, expected %0d", name, cyc, len + 1);
                    end
                end
                break;
            end
            checks++;
            if (bus.valid !== 1'b1 || bus.busy !== 1'b1 || idx >= len) begin
                errors++;
                $display("FAIL %s_valid: got valid=%b busy=%b beat=%0d, expected valid=1 busy=1 beat<%0d",
                         name, bus.valid, bus.busy, idx, len);
                break;
            end
            checks++;
            if (bus.addr !== beat_addr(base, idx, mask) || bus.beats_left !== 16'(len - idx)) begin
                errors++;
                $display("FAIL %s_beat%0d: got addr=%h left=%0d, expected addr=%h left=%0d", name, idx,
                         bus.addr, bus.beats_left, beat_addr(base, idx, mask), len - idx);
            end
            case (mode)
                0:       adv = 1'b1;
                1:       adv = (cyc % 2) == 1;
                default: adv = 1'($urandom_range(0, 1));
            endcase
            bus.advance = adv;
            if (mode == 2) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.load = 1'($urandom_range(0, 1));
                bus.base_addr = $urandom;
                bus.burst_len = 16'($urandom_range(0, 9));
            end
            if (adv) idx++;
            tick;
            cyc++;
        end
        bus.advance = 0; bus.start = 0; bus.load = 0;
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done pulse, expected one after %0d beats", name, len);
        end
        if (len > 0) model_addr = beat_addr(base, len, mask);
        tick;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.addr !== model_addr) begin
            errors++;
            $display("FAIL %s_after: got done=%b busy=%b valid=%b addr=%h, expected 0 0 0 addr=%h",
                     name, bus.done, bus.busy, bus.valid, bus.addr, model_addr);
        end
    endtask

    task automatic test_load;
        bus.base_addr = 32'h0000_5550; bus.load = 1; bus.abort = 1;
        tick;
        bus.load = 0; bus.abort = 0;
        model_addr = 32'h0000_5550;
        checks++;
        if (bus.addr !== model_addr || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: got addr=%h busy=%b valid=%b, expected addr=%h busy=0 valid=0",
                     bus.addr, bus.busy, bus.valid, model_addr);
        end
    endtask

    task automatic test_abort;
        bus.wrap_mask = 32'hFFFF_FFFF;
        bus.base_addr = 32'h0000_4000; bus.burst_len = 16'd8; bus.start = 1;
        tick;
        bus.start = 0; bus.advance = 1;
        tick;
        checks++;
        if (bus.valid !== 1'b1 || bus.addr !== 32'h0000_4004) begin
            errors++;
            $display("FAIL abort_second_beat: got valid=%b addr=%h, expected valid=1 addr=00004004", bus.valid, bus.addr);
        end
        bus.abort = 1;
        tick;
        bus.abort = 0; bus.advance = 0;
        model_addr = 32'h0000_4004;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.beats_left !== 16'h0 || bus.addr !== model_addr) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b done=%b left=%0d addr=%h, expected 0 0 0 0 addr=%h",
                     bus.busy, bus.valid, bus.done, bus.beats_left, bus.addr, model_addr);
        end
        tick;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done=%b, expected 0", bus.done);
        end
        run_burst(32'h0000_9000, 0, 0, 32'hFFFF_FFFF, "zero_len");
    endtask

    task automatic test_reset_mid_burst;
        bus.base_addr = 32'h0000_7000; bus.burst_len = 16'd8; bus.start = 1;
        tick;
        bus.start = 0; bus.advance = 1;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.valid, bus.busy, bus.done} !== 3'b000 || bus.addr !== 32'h0 || bus.beats_left !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_burst: got v/b/d=%b%b%b addr=%h left=%0d, expected 000 addr=0 left=0",
                     bus.valid, bus.busy, bus.done, bus.addr, bus.beats_left);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        bus.advance = 0;
        model_addr = 32'h0;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_stays_idle: got busy=%b valid=%b addr=%h, expected 0 0 addr=0",
                     bus.busy, bus.valid, bus.addr);
        end
    endtask

    task automatic test_random;
        logic [31:0] masks [3];
        masks[0] = 32'h0000_000F; masks[1] = 32'h0000_003F; masks[2] = 32'hFFFF_FFFF;
        for (int n = 0; n < 20; n++) begin
            run_burst($urandom, $urandom_range(0, 9), $urandom_range(0, 2),
                      masks[$urandom_range(0, 2)], "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef BURST_WRAP_EN
        wrap_en = 1'b1;
`else
        wrap_en = 1'b0;
`endif
        test_reset;
        run_burst(32'h0000_1000, 4, 0, 32'hFFFF_FFFF, "linear4");
        run_burst(32'h0000_1000, 4, 1, 32'hFFFF_FFFF, "toggle4");
        run_burst(32'hFFFF_FFFC, 2, 0, 32'hFFFF_FFFF, "overflow");
        run_burst(32'h0000_2008, 4, 0, 32'h0000_000F, "wrap");
        test_load;
        test_abort;
        test_reset_mid_burst;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
